// File: rtl/lfsr_rand_gen_if.sv
// Valid/ready output channel of the LFSR random-number generator.
// The master drives value/out_valid; the slave returns out_ready.
interface lfsr_rand_gen_if #(
    parameter int OUT_W = 3
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] value;

    modport master (
        output out_valid,
        output value,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  value,
        output out_ready
    );
endinterface

// File: rtl/lfsr_rand_gen.sv
// Fibonacci LFSR drawing bounded values in [0, RANGE) by rejection sampling.
// Define LFSR_NO_REPEAT_EN to reject repeats of the last delivered value.
module lfsr_rand_gen #(
    parameter int               WIDTH     = 13,
    parameter logic [WIDTH-1:0] TAPS      = 13'h100D,
    parameter logic [WIDTH-1:0] SEED      = 13'h0CAB,
    parameter int               OUT_W     = 3,
    parameter int               RANGE     = 7,
    parameter int               MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    lfsr_rand_gen_if.master  out_if,
    output logic [WIDTH-1:0] state_out
);

    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [OUT_W-1:0] RMOD  = OUT_W'(RANGE);
    localparam logic [OUT_W:0]   RLIM  = (OUT_W + 1)'(RANGE);
    localparam logic [TW-1:0]    TLAST = TW'(MAX_TRIES - 1);

    typedef enum logic {
        DRAW,
        HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             vld_q, vld_d;
    logic [OUT_W-1:0] val_q, val_d;
    logic [TW-1:0]    tries_q, tries_d;

    logic [OUT_W-1:0] cand;
    logic [OUT_W-1:0] fb_val;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] load_val;
    logic             in_rng;
    logic             rep;
    logic             accept;

    // A step landing on all-zeros would lock the LFSR, so reseed instead.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] n;
        n = {r[WIDTH-2:0], ^(r & TAPS)};
        return (n == '0) ? SEED : n;
    endfunction

    assign cand     = reg_q[OUT_W-1:0];
    assign stepped  = step(reg_q);
    assign load_val = (seed_in == '0) ? SEED : seed_in;
    assign in_rng   = {1'b0, cand} < RLIM;

`ifdef LFSR_NO_REPEAT_EN
    logic [OUT_W-1:0] last_q, last_d;
    logic             last_vld_q, last_vld_d;
    logic [OUT_W-1:0] f_raw;

    localparam logic [OUT_W-1:0] RMAX = OUT_W'(RANGE - 1);

    assign rep    = last_vld_q && (cand == last_q);
    assign f_raw  = in_rng ? cand : cand - RMOD;
    assign fb_val = (last_vld_q && f_raw == last_q)
                  ? ((last_q == RMAX) ? '0 : last_q + OUT_W'(1))
                  : f_raw;
`else
    assign rep    = 1'b0;
    assign fb_val = in_rng ? cand : cand - RMOD;
`endif

    assign accept = in_rng && !rep;

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        vld_d   = vld_q;
        val_d   = val_q;
        tries_d = tries_q;
`ifdef LFSR_NO_REPEAT_EN
        last_d     = last_q;
        last_vld_d = last_vld_q;
`endif
        if (seed_load) begin
            reg_d   = load_val;
            vld_d   = 1'b0;
            tries_d = '0;
            state_d = DRAW;
`ifdef LFSR_NO_REPEAT_EN
            last_vld_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                DRAW: begin
                    reg_d = stepped;
                    if (accept || tries_q == TLAST) begin
                        val_d   = accept ? cand : fb_val;
                        vld_d   = 1'b1;
                        tries_d = '0;
                        state_d = HOLD;
`ifdef LFSR_NO_REPEAT_EN
                        last_d     = accept ? cand : fb_val;
                        last_vld_d = 1'b1;
`endif
                    end else begin
                        tries_d = tries_q + TW'(1);
                    end
                end
                HOLD: begin
                    if (en) reg_d = stepped;
                    if (out_if.out_ready) begin
                        vld_d   = 1'b0;
                        state_d = DRAW;
                    end
                end
                default: state_d = DRAW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DRAW;
            reg_q   <= SEED;
            vld_q   <= 1'b0;
            val_q   <= '0;
            tries_q <= '0;
`ifdef LFSR_NO_REPEAT_EN
            last_q     <= '0;
            last_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            vld_q   <= vld_d;
            val_q   <= val_d;
            tries_q <= tries_d;
`ifdef LFSR_NO_REPEAT_EN
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
`endif
        end
    end

    assign out_if.out_valid = vld_q;
    assign out_if.value     = val_q;
    assign state_out        = reg_q;

endmodule
